// File: rtl/mux_gate_scheduler.sv
// rtl/mux_gate_scheduler.sv - round-robin scheduler sharing one mux-built logic unit among four requesters
module mux_gate_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] a_in,
  input  logic [4*WIDTH-1:0] b_in,
  input  logic [7:0]         op_in,
  output logic [3:0]         gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_id,
  output logic [1:0]         out_op
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  slot_e            state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       id_q, id_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       ptr_q, ptr_d;

  logic             free;
  logic             accept;
  logic             found;
  logic [1:0]       winner;
  logic [1:0]       idx;

  // Each opcode is one 2:1 mux per bit, with operand B driving the select.
  function automatic logic [WIDTH-1:0] gate_mux(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [1:0]       op
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (op)
        2'b00:   r[i] = b[i] ? a[i]  : 1'b0;
        2'b01:   r[i] = b[i] ? 1'b1  : a[i];
        2'b10:   r[i] = b[i] ? ~a[i] : a[i];
        default: r[i] = b[i] ? ~a[i] : 1'b1;
      endcase
    end
    return r;
  endfunction

  // Round-robin search from ptr upward with wrap; grant only when the slot can take a result.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    free   = (state_q == SLOT_EMPTY) || out_ready;
    accept = !rst && free && found;
    gnt    = accept ? (4'b0001 << winner) : 4'b0000;
  end

  // Slot next state and result capture; a drain without accept leaves the payload stale.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    op_d    = op_q;
    ptr_d   = ptr_q;
    case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL: begin
        if (accept)         state_d = SLOT_FULL;
        else if (out_ready) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase
    if (accept) begin
      data_d = gate_mux(a_in[winner*WIDTH +: WIDTH], b_in[winner*WIDTH +: WIDTH],
                        op_in[2*winner +: 2]);
      id_d   = winner;
      op_d   = op_in[2*winner +: 2];
      ptr_d  = winner + 2'd1;
    end
  end

  // State registers; reset discards any undelivered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      id_q    <= 2'd0;
      op_q    <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign out_op    = op_q;

endmodule

// File: tb/tb_mux_gate_scheduler.sv
// tb/tb_mux_gate_scheduler.sv - scoreboard bench for mux_gate_scheduler
module tb_mux_gate_scheduler;

  localparam int WIDTH = 4;

  logic               clk;
  logic               rst;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] a_in;
  logic [4*WIDTH-1:0] b_in;
  logic [7:0]         op_in;
  logic [3:0]         gnt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_id;
  logic [1:0]         out_op;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       id;
    logic [1:0]       op;
  } res_t;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic flush_pending = 1'b0;

  mux_gate_scheduler #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_op(out_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Monitor: compare the presented result with the scoreboard head; pop on delivery.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result: got data=%b id=%0d op=%0d, required nothing pending",
                 out_data, out_id, out_op);
      end else begin
        if (out_data !== exp_q[0].data || out_id !== exp_q[0].id || out_op !== exp_q[0].op) begin
          errors++;
          $display("FAIL result: got data=%b id=%0d op=%0d, required data=%b id=%0d op=%0d",
                   out_data, out_id, out_op, exp_q[0].data, exp_q[0].id, exp_q[0].op);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus; checks gnt and, optionally, an empty or reset-valued slot.
  task automatic vec(input logic r, input logic [3:0] rq, input logic [15:0] a,
                     input logic [15:0] b, input logic [7:0] op, input logic rdy,
                     input logic [3:0] eg, input logic [3:0] ed, input logic [1:0] eid,
                     input logic [1:0] eop, input logic chk_empty, input logic chk_rst);
    res_t e;
    @(posedge clk);
    if (flush_pending) begin
      exp_q.delete();
      flush_pending = 1'b0;
    end
    #1;
    rst = r; req = rq; a_in = a; b_in = b; op_in = op; out_ready = rdy;
    @(negedge clk);
    checks++;
    if (gnt !== eg) begin
      errors++;
      $display("FAIL gnt: got %b, required %b", gnt, eg);
    end
    if (chk_empty) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL empty_slot: got out_valid=%b, required 0", out_valid);
      end
    end
    if (chk_rst) begin
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_id !== 2'd0 || out_op !== 2'd0) begin
        errors++;
        $display("FAIL reset_state: got v=%b d=%b id=%0d op=%0d, required 0 0 0 0",
                 out_valid, out_data, out_id, out_op);
      end
    end
    if (eg != 4'b0000) begin
      e.data = ed; e.id = eid; e.op = eop;
      exp_q.push_back(e);
    end
    if (r) flush_pending = 1'b1;
  endtask

  localparam logic [15:0] A = 16'hCCCC;
  localparam logic [15:0] B = 16'hAAAA;
  localparam logic [7:0]  OPS = 8'b11_10_01_00;

  initial begin
    rst = 1'b1; req = 4'b0; a_in = '0; b_in = '0; op_in = '0; out_ready = 1'b0;
    // reset with all requests asserted
    vec(1, 4'b1111, A, B, 8'h00, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vec(1, 4'b1111, A, B, 8'h00, 1, 4'b0000, 4'b0000, 0, 0, 0, 1);
    vec(0, 4'b1111, A, B, 8'h00, 1, 4'b0001, 4'b1000, 0, 0, 0, 1);
    // opcode sweep on requester 2
    vec(0, 4'b0100, A, B, 8'b00_00_00_00, 1, 4'b0100, 4'b1000, 2, 0, 0, 0);
    vec(0, 4'b0100, A, B, 8'b00_01_00_00, 1, 4'b0100, 4'b1110, 2, 1, 0, 0);
    vec(0, 4'b0100, A, B, 8'b00_10_00_00, 1, 4'b0100, 4'b0110, 2, 2, 0, 0);
    vec(0, 4'b0100, A, B, 8'b00_11_00_00, 1, 4'b0100, 4'b0111, 2, 3, 0, 0);
    // round robin from ptr=3
    vec(0, 4'b1111, A, B, OPS, 1, 4'b1000, 4'b0111, 3, 3, 0, 0);
    vec(0, 4'b1111, A, B, OPS, 1, 4'b0001, 4'b1000, 0, 0, 0, 0);
    vec(0, 4'b1111, A, B, OPS, 1, 4'b0010, 4'b1110, 1, 1, 0, 0);
    vec(0, 4'b1111, A, B, OPS, 1, 4'b0100, 4'b0110, 2, 2, 0, 0);
    vec(0, 4'b1111, A, B, OPS, 1, 4'b1000, 4'b0111, 3, 3, 0, 0);
    // back-pressure for 3 cycles, then accept with no bubble
    vec(0, 4'b0011, A, B, OPS, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vec(0, 4'b0011, A, B, OPS, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vec(0, 4'b0011, A, B, OPS, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vec(0, 4'b0011, A, B, OPS, 1, 4'b0001, 4'b1000, 0, 0, 0, 0);
    // sparse requests and pointer wrap
    vec(0, 4'b0100, A, B, OPS, 1, 4'b0100, 4'b0110, 2, 2, 0, 0);
    vec(0, 4'b0011, A, B, OPS, 1, 4'b0001, 4'b1000, 0, 0, 0, 0);
    vec(0, 4'b0011, A, B, OPS, 1, 4'b0010, 4'b1110, 1, 1, 0, 0);
    vec(0, 4'b0000, A, B, OPS, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vec(0, 4'b0000, A, B, OPS, 1, 4'b0000, 4'b0000, 0, 0, 1, 0);
    // mid-operation reset discards the pending result
    vec(0, 4'b0001, A, B, OPS, 0, 4'b0001, 4'b1000, 0, 0, 0, 0);
    vec(1, 4'b0001, A, B, OPS, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vec(0, 4'b1000, A, B, OPS, 1, 4'b1000, 4'b0111, 3, 3, 0, 1);
    vec(0, 4'b0000, A, B, OPS, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vec(0, 4'b0000, A, B, OPS, 1, 4'b0000, 4'b0000, 0, 0, 1, 0);
    // different operands: requester 1 NAND, a=0101 b=0011 -> 1110
    vec(0, 4'b0010, 16'hCC5C, 16'hAA3A, 8'b00_00_11_00, 1, 4'b0010, 4'b1110, 1, 3, 0, 0);
    vec(0, 4'b0000, A, B, OPS, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vec(0, 4'b0000, A, B, OPS, 1, 4'b0000, 4'b0000, 0, 0, 1, 0);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drained: got %0d undelivered results, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
